// File: rtl/seg595_defs.sv
// Shared constants and state encoding for the 74HC595 scan display path.
package seg595_defs;

   localparam int FRAME_W    = 14;
   localparam int SEL_W      = 6;
   localparam int BIT_CLKS   = 4;
   localparam int STCP_CLKS  = 2;
   localparam int BIT_IDX_W  = $clog2(FRAME_W);
   localparam int PHASE_W    = $clog2(BIT_CLKS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } ser_state_t;

endpackage

// File: rtl/hc595_serializer.sv
// Shifts one frame MSB-first into the 595 chain, then pulses the storage clock.
module hc595_serializer
   import seg595_defs::*;
(
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame_in,
   output logic               ds,
   output logic               shcp,
   output logic               stcp,
   output logic               done,
   output logic               idle,
   output logic               latch_last
);

   ser_state_t             state, state_n;
   logic [FRAME_W-1:0]     frame_q, frame_n;
   logic [BIT_IDX_W-1:0]   bit_idx, bit_n;
   logic [PHASE_W-1:0]     phase, phase_n;
   logic                   ds_n, shcp_n, stcp_n, done_n;

   assign idle = (state == IDLE);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         frame_q <= '0;
         bit_idx <= '0;
         phase   <= '0;
         ds      <= 1'b0;
         shcp    <= 1'b0;
         stcp    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         frame_q <= frame_n;
         bit_idx <= bit_n;
         phase   <= phase_n;
         ds      <= ds_n;
         shcp    <= shcp_n;
         stcp    <= stcp_n;
         done    <= done_n;
      end
   end

   // ds moves only when a bit starts; shcp rises two cycles later so ds is long settled.
   always_comb begin
      state_n    = state;
      frame_n    = frame_q;
      bit_n      = bit_idx;
      phase_n    = phase;
      ds_n       = ds;
      shcp_n     = 1'b0;
      stcp_n     = 1'b0;
      done_n     = 1'b0;
      latch_last = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = SHIFT;
               frame_n = frame_in;
               ds_n    = frame_in[FRAME_W-1];
               bit_n   = BIT_IDX_W'(FRAME_W-1);
               phase_n = '0;
            end
         end
         SHIFT: begin
            phase_n = phase + PHASE_W'(1);
            if (phase == PHASE_W'(BIT_CLKS-1)) begin
               phase_n = '0;
               if (bit_idx == '0) begin
                  state_n = LATCH;
                  stcp_n  = 1'b1;
               end else begin
                  bit_n   = bit_idx - BIT_IDX_W'(1);
                  frame_n = {frame_q[FRAME_W-2:0], 1'b0};
                  ds_n    = frame_q[FRAME_W-2];
               end
            end
            shcp_n = (state_n == SHIFT) && (phase_n >= PHASE_W'(BIT_CLKS/2));
         end
         LATCH: begin
            phase_n = phase + PHASE_W'(1);
            stcp_n  = 1'b1;
            if (phase == PHASE_W'(STCP_CLKS-1)) begin
               latch_last = 1'b1;
               state_n    = IDLE;
               phase_n    = '0;
               stcp_n     = 1'b0;
               done_n     = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/seg_595_scan_ctrl.sv
// Dynamic-scan scheduler: one digit frame per scan period onto the 595 chain.
module seg_595_scan_ctrl
   import seg595_defs::*;
#(
   parameter int          DIG_NUM      = 6,
   parameter logic [24:0] SCAN_CNT_MAX = 25'd49_999,
   parameter int          SEG_W        = 8
)
(
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [DIG_NUM*SEG_W-1:0] seg_data,
   input  logic [DIG_NUM-1:0]       dig_en,
   output logic                     stcp,
   output logic                     shcp,
   output logic                     ds,
   output logic                     oe,
   output logic                     frame_done
);

   localparam int IDX_W = $clog2(DIG_NUM);

   logic [24:0]        scan_cnt;
   logic [IDX_W-1:0]   dig_idx;
   logic               tick, tick_pend, start;
   logic               ser_idle, latch_last;
   logic [SEG_W-1:0]   code;
   logic [SEL_W-1:0]   sel;
   logic [FRAME_W-1:0] frame;

   assign tick  = (scan_cnt == SCAN_CNT_MAX);
   assign start = ser_idle && (tick || tick_pend);

   // A tick that lands while a frame is still in flight is parked for one slot.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         scan_cnt  <= '0;
         tick_pend <= 1'b0;
         dig_idx   <= '0;
         oe        <= 1'b1;
      end else begin
         scan_cnt <= tick ? '0 : scan_cnt + 25'd1;
         if (start)
            tick_pend <= 1'b0;
         else if (tick)
            tick_pend <= 1'b1;
         if (latch_last) begin
            dig_idx <= (dig_idx == IDX_W'(DIG_NUM-1)) ? '0 : dig_idx + IDX_W'(1);
            oe      <= 1'b0;
         end
      end
   end

   always_comb begin
      code = '0;
      sel  = '0;
      for (int i = 0; i < DIG_NUM; i++) begin
         if (dig_idx == IDX_W'(i)) begin
            code   = seg_data[i*SEG_W +: SEG_W];
            sel[i] = dig_en[i];
         end
      end
      frame = {code, sel};
   end

   hc595_serializer u_serializer (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .frame_in   (frame),
      .ds         (ds),
      .shcp       (shcp),
      .stcp       (stcp),
      .done       (frame_done),
      .idle       (ser_idle),
      .latch_last (latch_last)
   );

endmodule
